led_pattern_driver: RTL and testbench
=====================================

Name: led_pattern_driver

Overview:
- Downstream consumer of the led_2 AXI slave register bank. Takes single-cycle configuration writes decoded from S00_AXI and drives the physical LED pins.
- Supported modes: static, blink, rotate and PWM dimming. Timing comes from a programmable prescaler.
- Status outputs are fed back into the register bank's read path.

Parameters:
- NUM_LEDS, 8, width of the pattern and of led_out (2..32).
- PRESCALE_W, 32, width of the PERIOD register and prescaler counter.
- PWM_W, 8, width of the DUTY register and PWM counter.

Ports:
- ACLK  in  1  system clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- cfg_wr_en  in  1  one-cycle write strobe from the register bank.
- cfg_addr  in  2  register select: 0 CTRL, 1 PATTERN, 2 PERIOD, 3 DUTY.
- cfg_wdata  in  32  write data; each register uses its low bits.
- led_out  out  NUM_LEDS  registered LED drive.
- tick  out  1  one-cycle pulse at prescaler terminal count.
- running  out  1  high while the FSM is in RUN.
- cur_pattern  out  NUM_LEDS  current working/rotate register.
- step_cnt  out  16  ticks counted in RUN; wraps from 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync release): led_out, tick, running, cur_pattern and step_cnt are 0. All config registers, prescaler, phase and PWM counter are 0. FSM is IDLE.
- Config register fields:
  - CTRL[0] = enable.
  - CTRL[2:1] = mode: 0 STATIC, 1 BLINK, 2 ROTATE, 3 PWM.
  - PATTERN[NUM_LEDS-1:0], PERIOD[PRESCALE_W-1:0], DUTY[PWM_W-1:0].
- Writes: a register is updated on the edge where cfg_wr_en=1. The new value affects led_out one cycle later.
- Prescaler:
  - Counts 0..PERIOD while in RUN. tick=1 in the cycle where count==PERIOD, then the counter wraps to 0.
  - PERIOD=0 gives tick every cycle.
  - A PERIOD write restarts the count at 0, with no tick that cycle.
- FSM:
  - IDLE -> RUN on the cycle after enable becomes 1.
  - RUN -> IDLE on the cycle after enable becomes 0.
  - In IDLE: prescaler, phase and PWM counter are held at 0, and led_out=0.
- Entering RUN, a CTRL write that changes mode, or a PATTERN write: cur_pattern<=PATTERN, phase<=1, PWM counter<=0, prescaler<=0.
- Mode behaviour in RUN (led_out registered):
  - STATIC: led_out=PATTERN.
  - BLINK: phase toggles on each tick; led_out = phase ? PATTERN : 0. The first half-period is on.
  - ROTATE: cur_pattern rotates left by 1 on each tick (MSB wraps to bit 0); led_out=cur_pattern.
  - PWM: counter increments on each tick (wraps at 2^PWM_W); led_out = (pwm_cnt < DUTY) ? PATTERN : 0. DUTY=0 gives always off; DUTY=2^PWM_W-1 gives off for one step per cycle.
- step_cnt increments on every tick in RUN. It is cleared only by reset, not on IDLE.
- Simultaneous events:
  - A disabling CTRL write in the same cycle as a tick: the disable wins, but the tick is still output and counted.
  - A PATTERN write in the same cycle as a rotate tick: the reload wins and the rotation is discarded.
- Writes to cfg_addr values other than the four listed cannot occur (2-bit field). Unused high bits of cfg_wdata are ignored.
- Reset asserted mid-operation clears everything immediately, including led_out.

Decomposition:
- Package led_2_pkg holds:
  - Register address localparams ADDR_CTRL..ADDR_DUTY.
  - Enum led_mode_t {LED_STATIC, LED_BLINK, LED_ROTATE, LED_PWM}.
  - Enum led_state_t {ST_IDLE, ST_RUN}.
- One sub-module, led_prescaler: counter, terminal-count compare, tick output, sync restart input and enable input.

Test Plan:
- Write PATTERN=0xA5, CTRL=0x1 (STATIC, enabled) -> running=1 two cycles after the CTRL write. led_out=0xA5 from then on; tick pulses every cycle (PERIOD=0).
- PERIOD=3, PATTERN=0x0F, CTRL=0x3 (BLINK) -> tick every 4 cycles. led_out alternates 0x0F/0x00 every 4 cycles, starting at 0x0F; step_cnt increments by 1 per tick.
- PERIOD=0, PATTERN=0x81, CTRL=0x5 (ROTATE) -> led_out sequence 0x81, 0x03, 0x06, 0x0C... A PATTERN=0x01 write in the same cycle as a tick gives led_out=0x01 the next cycle.
- PERIOD=0, PATTERN=0xFF, DUTY=64, CTRL=0x7 (PWM) -> over 256 cycles led_out=0xFF for exactly 64 cycles. DUTY=0 gives 0 cycles on.
- While ROTATE is running, write CTRL=0x4 (enable cleared) -> led_out=0 and running=0 within 2 cycles. The tick in the write cycle is still counted in step_cnt.
- Deassert ARESETN mid-blink, between clock edges -> led_out, tick, running and cur_pattern go to 0 immediately. After release the FSM stays IDLE until CTRL is rewritten.

Source files
------------

// File: rtl/led_2_pkg.sv
// Shared register map and type definitions for the LED pattern driver.
package led_2_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_DUTY    = 2'd3;

    typedef enum logic [1:0] {
        LED_STATIC = 2'd0,
        LED_BLINK  = 2'd1,
        LED_ROTATE = 2'd2,
        LED_PWM    = 2'd3
    } led_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } led_state_t;

endpackage

// File: rtl/led_pattern_driver_if.sv
// Single-cycle configuration write port from the register bank.
interface led_pattern_driver_if;

    logic        cfg_wr_en;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;

    modport master (output cfg_wr_en, output cfg_addr, output cfg_wdata);
    modport slave  (input  cfg_wr_en, input  cfg_addr, input  cfg_wdata);

endinterface

// File: rtl/led_pattern_driver_prescaler.sv
// Down-rate tick generator: counts 0..period while enabled and pulses tick at the top.
module led_prescaler #(
    parameter int W = 32
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         en,
    input  logic         restart,
    input  logic         clr,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    // restart also swallows the tick of its own cycle; clr only rewinds the count
    always_comb begin
        tick  = en && !restart && (cnt_q == period);
        cnt_d = cnt_q + W'(1);
        if (!en || restart || clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_driver.sv
// LED pattern driver: static / blink / rotate / PWM modes over a programmable prescaler.
// state   | meaning
// ST_IDLE | outputs dark, working counters held at 0
// ST_RUN  | selected mode drives led_out, prescaler running
module led_pattern_driver
    import led_2_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int PRESCALE_W = 32,
    parameter int PWM_W      = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    led_pattern_driver_if.slave   cfg,
    output logic [NUM_LEDS-1:0]   led_out,
    output logic                  tick,
    output logic                  running,
    output logic [NUM_LEDS-1:0]   cur_pattern,
    output logic [15:0]           step_cnt
);

    led_state_t              state_q, state_d;
    logic [2:0]              ctrl_q, ctrl_d;
    logic [NUM_LEDS-1:0]     pattern_q, pattern_d;
    logic [PRESCALE_W-1:0]   period_q, period_d;
    logic [PWM_W-1:0]        duty_q, duty_d;
    logic [NUM_LEDS-1:0]     cur_q, cur_d;
    logic                    phase_q, phase_d;
    logic [PWM_W-1:0]        pwm_q, pwm_d;
    logic [NUM_LEDS-1:0]     led_q, led_d;
    logic [15:0]             step_q, step_d;

    logic      wr_ctrl, wr_pattern, wr_period, wr_duty;
    logic      reload;
    led_mode_t mode_q, mode_d;

    always_comb begin
        wr_ctrl    = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_CTRL);
        wr_pattern = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_PATTERN);
        wr_period  = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_PERIOD);
        wr_duty    = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_DUTY);
        ctrl_d     = wr_ctrl    ? cfg.cfg_wdata[2:0]            : ctrl_q;
        pattern_d  = wr_pattern ? cfg.cfg_wdata[NUM_LEDS-1:0]   : pattern_q;
        period_d   = wr_period  ? cfg.cfg_wdata[PRESCALE_W-1:0] : period_q;
        duty_d     = wr_duty    ? cfg.cfg_wdata[PWM_W-1:0]      : duty_q;
        mode_q     = led_mode_t'(ctrl_q[2:1]);
        mode_d     = led_mode_t'(ctrl_d[2:1]);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ctrl_q[0])  state_d = ST_RUN;
            ST_RUN:  if (!ctrl_q[0]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Entering RUN, switching mode or loading a new pattern restarts the animation
    always_comb begin
        reload = ((state_q == ST_IDLE) && (state_d == ST_RUN)) ||
                 (running && (wr_pattern ||
                              (wr_ctrl && (cfg.cfg_wdata[2:1] != ctrl_q[2:1]))));
    end

    led_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .en      (running),
        .restart (wr_period),
        .clr     (reload),
        .period  (period_q),
        .tick    (tick)
    );

    always_comb begin
        cur_d   = cur_q;
        phase_d = phase_q;
        pwm_d   = pwm_q;
        if (state_d == ST_IDLE) begin
            phase_d = 1'b0;
            pwm_d   = '0;
        end else if (reload) begin
            cur_d   = pattern_d;
            phase_d = 1'b1;
            pwm_d   = '0;
        end else if (tick) begin
            case (mode_q)
                LED_BLINK:  phase_d = !phase_q;
                LED_ROTATE: cur_d   = {cur_q[NUM_LEDS-2:0], cur_q[NUM_LEDS-1]};
                LED_PWM:    pwm_d   = pwm_q + PWM_W'(1);
                default:    ;
            endcase
        end

        led_d = '0;
        if (state_d == ST_RUN) begin
            case (mode_d)
                LED_STATIC: led_d = pattern_d;
                LED_BLINK:  led_d = phase_d ? pattern_d : '0;
                LED_ROTATE: led_d = cur_d;
                LED_PWM:    led_d = (pwm_d < duty_d) ? pattern_d : '0;
                default:    led_d = '0;
            endcase
        end

        step_d = tick ? step_q + 16'd1 : step_q;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_q    <= '0;
            pattern_q <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            cur_q     <= '0;
            phase_q   <= 1'b0;
            pwm_q     <= '0;
            led_q     <= '0;
            step_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            cur_q     <= cur_d;
            phase_q   <= phase_d;
            pwm_q     <= pwm_d;
            led_q     <= led_d;
            step_q    <= step_d;
        end
    end

    assign led_out     = led_q;
    assign cur_pattern = cur_q;
    assign step_cnt    = step_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver; all activity on falling edges.
module tb_led_pattern_driver;

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b0;
    logic [7:0]  led_out;
    logic        tick;
    logic        running;
    logic [7:0]  cur_pattern;
    logic [15:0] step_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [7:0] ROT_EXP [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};

    led_pattern_driver_if cfg_if ();

    led_pattern_driver #(.NUM_LEDS(8), .PRESCALE_W(32), .PWM_W(8)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg         (cfg_if.slave),
        .led_out     (led_out),
        .tick        (tick),
        .running     (running),
        .cur_pattern (cur_pattern),
        .step_cnt    (step_cnt)
    );

    always #5 ACLK = ~ACLK;

    task automatic do_reset();
        ARESETN          = 1'b0;
        cfg_if.cfg_wr_en = 1'b0;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_wdata = 32'd0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        #1;
    endtask

    // drives the write for the current cycle and returns one cycle later
    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_if.cfg_wr_en = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_wdata = d;
        @(negedge ACLK);
        cfg_if.cfg_wr_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        #1;
        n_checks++; if (led_out !== 8'h00) $display("FAIL reset_led: got %h want 00", led_out); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running); else n_pass++;
        n_checks++; if (cur_pattern !== 8'h00) $display("FAIL reset_cur: got %h want 00", cur_pattern); else n_pass++;
        n_checks++; if (step_cnt !== 16'd0) $display("FAIL reset_step: got %0d want 0", step_cnt); else n_pass++;
    endtask

    task automatic test_static();
        do_reset();
        cfg_write(2'd1, 32'hFFFF_FFA5);
        cfg_write(2'd0, 32'h1);
        n_checks++; if (running !== 1'b0) $display("FAIL static_running_early: got %b want 0", running); else n_pass++;
        @(negedge ACLK);
        n_checks++; if (running !== 1'b1) $display("FAIL static_running: got %b want 1", running); else n_pass++;
        n_checks++; if (led_out !== 8'hA5) $display("FAIL static_led_first: got %h want a5", led_out); else n_pass++;
        n_checks++; if (step_cnt !== 16'd0) $display("FAIL static_step0: got %0d want 0", step_cnt); else n_pass++;
        for (int k = 1; k <= 6; k++) begin
            @(negedge ACLK);
            n_checks++; if (led_out !== 8'hA5) $display("FAIL static_led k=%0d: got %h want a5", k, led_out); else n_pass++;
            n_checks++; if (tick !== 1'b1) $display("FAIL static_tick k=%0d: got %b want 1", k, tick); else n_pass++;
        end
        n_checks++; if (step_cnt !== 16'd6) $display("FAIL static_step6: got %0d want 6", step_cnt); else n_pass++;
        cfg_if.cfg_wr_en = 1'b1;
        cfg_if.cfg_addr  = 2'd2;
        cfg_if.cfg_wdata = 32'd0;
        #1;
        n_checks++; if (tick !== 1'b0) $display("FAIL period_write_tick: got %b want 0", tick); else n_pass++;
        @(negedge ACLK);
        cfg_if.cfg_wr_en = 1'b0;
        #1;
        n_checks++; if (tick !== 1'b1) $display("FAIL period_after_tick: got %b want 1", tick); else n_pass++;
        n_checks++; if (step_cnt !== 16'd6) $display("FAIL period_step: got %0d want 6", step_cnt); else n_pass++;
    endtask

    task automatic test_blink();
        logic [7:0] exp_led;
        do_reset();
        cfg_write(2'd2, 32'd3);
        cfg_write(2'd1, 32'h0F);
        cfg_write(2'd0, 32'h3);
        @(negedge ACLK);
        for (int j = 0; j < 16; j++) begin
            exp_led = (((j / 4) % 2) == 0) ? 8'h0F : 8'h00;
            n_checks++; if (led_out !== exp_led) $display("FAIL blink_led j=%0d: got %h want %h", j, led_out, exp_led); else n_pass++;
            n_checks++; if (tick !== ((j % 4) == 3)) $display("FAIL blink_tick j=%0d: got %b", j, tick); else n_pass++;
            n_checks++; if (step_cnt !== 16'(j / 4)) $display("FAIL blink_step j=%0d: got %0d want %0d", j, step_cnt, j / 4); else n_pass++;
            @(negedge ACLK);
        end
    endtask

    task automatic test_rotate();
        do_reset();
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd1, 32'h81);
        cfg_write(2'd0, 32'h5);
        @(negedge ACLK);
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (led_out !== ROT_EXP[j]) $display("FAIL rotate_led j=%0d: got %h want %h", j, led_out, ROT_EXP[j]); else n_pass++;
            n_checks++; if (cur_pattern !== ROT_EXP[j]) $display("FAIL rotate_cur j=%0d: got %h want %h", j, cur_pattern, ROT_EXP[j]); else n_pass++;
            @(negedge ACLK);
        end
        n_checks++; if (led_out !== 8'h18) $display("FAIL rotate_led j=4: got %h want 18", led_out); else n_pass++;
        cfg_if.cfg_wr_en = 1'b1;
        cfg_if.cfg_addr  = 2'd1;
        cfg_if.cfg_wdata = 32'h01;
        #1;
        n_checks++; if (tick !== 1'b1) $display("FAIL rotate_reload_tick: got %b want 1", tick); else n_pass++;
        @(negedge ACLK);
        cfg_if.cfg_wr_en = 1'b0;
        #1;
        n_checks++; if (led_out !== 8'h01) $display("FAIL rotate_reload_led: got %h want 01", led_out); else n_pass++;
        n_checks++; if (cur_pattern !== 8'h01) $display("FAIL rotate_reload_cur: got %h want 01", cur_pattern); else n_pass++;
        @(negedge ACLK);
        n_checks++; if (led_out !== 8'h02) $display("FAIL rotate_after_reload: got %h want 02", led_out); else n_pass++;
    endtask

    task automatic test_pwm();
        int on_cnt;
        do_reset();
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd1, 32'hFF);
        cfg_write(2'd3, 32'd64);
        cfg_write(2'd0, 32'h7);
        @(negedge ACLK);
        n_checks++; if (led_out !== 8'hFF) $display("FAIL pwm_first: got %h want ff", led_out); else n_pass++;
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out === 8'hFF) on_cnt++;
            @(negedge ACLK);
        end
        n_checks++; if (on_cnt != 64) $display("FAIL pwm_duty64: got %0d on want 64", on_cnt); else n_pass++;
        cfg_write(2'd3, 32'd0);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out !== 8'h00) on_cnt++;
            @(negedge ACLK);
        end
        n_checks++; if (on_cnt != 0) $display("FAIL pwm_duty0: got %0d on want 0", on_cnt); else n_pass++;
        cfg_write(2'd3, 32'hFFFF_FFFF);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out === 8'hFF) on_cnt++;
            @(negedge ACLK);
        end
        n_checks++; if (on_cnt != 255) $display("FAIL pwm_duty255: got %0d on want 255", on_cnt); else n_pass++;
    endtask

    task automatic test_disable();
        do_reset();
        cfg_write(2'd1, 32'h81);
        cfg_write(2'd0, 32'h5);
        @(negedge ACLK);
        repeat (3) @(negedge ACLK);
        n_checks++; if (step_cnt !== 16'd3) $display("FAIL disable_step_before: got %0d want 3", step_cnt); else n_pass++;
        cfg_if.cfg_wr_en = 1'b1;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_wdata = 32'h4;
        #1;
        n_checks++; if (tick !== 1'b1) $display("FAIL disable_write_tick: got %b want 1", tick); else n_pass++;
        @(negedge ACLK);
        cfg_if.cfg_wr_en = 1'b0;
        #1;
        n_checks++; if (running !== 1'b1) $display("FAIL disable_running_w1: got %b want 1", running); else n_pass++;
        n_checks++; if (step_cnt !== 16'd4) $display("FAIL disable_step_w1: got %0d want 4", step_cnt); else n_pass++;
        @(negedge ACLK);
        n_checks++; if (running !== 1'b0) $display("FAIL disable_running: got %b want 0", running); else n_pass++;
        n_checks++; if (led_out !== 8'h00) $display("FAIL disable_led: got %h want 00", led_out); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL disable_tick: got %b want 0", tick); else n_pass++;
        n_checks++; if (step_cnt !== 16'd5) $display("FAIL disable_step: got %0d want 5", step_cnt); else n_pass++;
        repeat (3) @(negedge ACLK);
        n_checks++; if (step_cnt !== 16'd5) $display("FAIL disable_step_hold: got %0d want 5", step_cnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_write(2'd2, 32'd3);
        cfg_write(2'd1, 32'h0F);
        cfg_write(2'd0, 32'h3);
        @(negedge ACLK);
        repeat (3) @(negedge ACLK);
        n_checks++; if (led_out !== 8'h0F) $display("FAIL areset_pre_led: got %h want 0f", led_out); else n_pass++;
        n_checks++; if (tick !== 1'b1) $display("FAIL areset_pre_tick: got %b want 1", tick); else n_pass++;
        #2;
        ARESETN = 1'b0;
        #1;
        n_checks++; if (led_out !== 8'h00) $display("FAIL areset_led: got %h want 00", led_out); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL areset_tick: got %b want 0", tick); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL areset_running: got %b want 0", running); else n_pass++;
        n_checks++; if (cur_pattern !== 8'h00) $display("FAIL areset_cur: got %h want 00", cur_pattern); else n_pass++;
        n_checks++; if (step_cnt !== 16'd0) $display("FAIL areset_step: got %0d want 0", step_cnt); else n_pass++;
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);
        n_checks++; if (running !== 1'b0) $display("FAIL areset_stay_idle: got %b want 0", running); else n_pass++;
        n_checks++; if (led_out !== 8'h00) $display("FAIL areset_idle_led: got %h want 00", led_out); else n_pass++;
        cfg_write(2'd1, 32'h3C);
        cfg_write(2'd0, 32'h1);
        @(negedge ACLK);
        n_checks++; if (running !== 1'b1) $display("FAIL areset_rerun: got %b want 1", running); else n_pass++;
        n_checks++; if (led_out !== 8'h3C) $display("FAIL areset_rerun_led: got %h want 3c", led_out); else n_pass++;
    endtask

    initial begin
        cfg_if.cfg_wr_en = 1'b0;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_wdata = 32'd0;
        test_reset();
        test_static();
        test_blink();
        test_rotate();
        test_pwm();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
